ref_mem_banked: RTL and testbench
=================================

Name: ref_mem_banked

Overview:
- Parametrised reference-pixel store for the ME datapath, built as COLS column banks. Each bank word holds ROWS vertically stacked pixels of one column.
- Written a lane-group at a time from the external fetch path.
- Read out as either one full ROWS×COLS block, a single selected row, or an auto-sequenced burst of all rows.
- Output uses a ready/valid handshake with a 2-entry output buffer so the SAD array can stall it.

Parameters:
- PIXEL_W, 8, bits per pixel
- COLS, 32, column banks (pixels per row)
- ROWS, 8, pixel rows per bank word
- DEPTH, 96, words per bank
- WR_LANES, 4, bank words written per write beat
- AW, $clog2(DEPTH), address width
- RW, $clog2(ROWS), row-index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_bank_mask  in  COLS  bank j written iff bit j set
- wr_addr  in  COLS*AW  per-bank write address, bank j at [AW*j +: AW]
- wr_data  in  WR_LANES*ROWS*PIXEL_W  bank j takes lane j%WR_LANES
- rd_req  in  1  read command valid
- rd_mode  in  2  0=BLOCK, 1=ROW, 2=BURST, 3=reserved
- rd_addr  in  AW  word address, common to all banks
- rd_row  in  RW  row index for ROW mode
- rd_ack  out  1  command accepted this cycle (rd_req && idle)
- out_data  out  ROWS*COLS*PIXEL_W  block, or row in low COLS*PIXEL_W bits
- out_row  out  RW  row index of a row beat (0 in BLOCK)
- out_block  out  1  beat is a full block
- out_last  out  1  final beat of the command
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat

Behaviour:
- Reset: all outputs 0, FSM IDLE, row counter 0, credit counter 2, buffer empty. Memory contents undefined (no clear).
- Reset mid-burst aborts the command and flushes in-flight and buffered beats. No beat appears after reset release until a new command is issued.
- Write:
  - Synchronous on wr_en, independent of the read FSM.
  - Same bank, same address, same cycle as a read: read-first, old data returned.
  - wr_bank_mask = 0 with wr_en = 1 is a no-op.
- Row layout: row r of bank j is bits [PIXEL_W*(r+1)-1 : PIXEL_W*r] of bank word j. Output row r column j is at [PIXEL_W*(COLS*r+j) +: PIXEL_W].
- FSM states IDLE, ISSUE_ONE, BURST:
  - IDLE: rd_ack = rd_req. Mode 0 or 1 goes to ISSUE_ONE. Mode 2 goes to BURST with row counter = 0. Mode 3: acked, no beat produced, stays IDLE.
  - ISSUE_ONE: issues one bank read when credit > 0, then returns to IDLE.
  - BURST: issues one read per cycle when credit > 0, row counter increments. After issuing row ROWS-1, returns to IDLE.
  - A new command is accepted in the same cycle the FSM returns to IDLE only on the following cycle (rd_ack needs state == IDLE).
- Pipeline:
  - Bank read 1 cycle, then a select/format register, then the buffer.
  - Latency from rd_ack to out_valid is 2 cycles when the buffer is empty.
  - BURST reads the bank word once per row beat; rd_addr is latched at ack.
- Credits:
  - Credit = 2 − (buffer occupancy + reads in flight).
  - Decrements on issue, increments on out_valid && out_ready. Both in one cycle leaves it unchanged.
  - Never issue at credit 0. No beat is ever dropped or duplicated.
  - With out_ready held high, BURST delivers ROWS beats on ROWS consecutive cycles.
- Formatting:
  - ROW and BURST beats zero the upper (ROWS−1)*COLS*PIXEL_W bits.
  - out_last = 1 on the BLOCK beat, the ROW beat, and BURST row ROWS-1.
- Handshake: out_data, out_row, out_block and out_last hold stable while out_valid && !out_ready.

Decomposition:
- Package ref_mem_pkg: the rd_mode encoding constants (MODE_BLOCK, MODE_ROW, MODE_BURST) and the FSM state enum.
- Sub-module ref_bank: single-port-read / single-port-write synchronous RAM, ROWS*PIXEL_W wide, DEPTH deep, read-first. Generated COLS times.
- FSM, credit counter and the 2-entry output buffer stay in the top level.

Test Plan:
- Write 8 beats with one-hot-group masks filling address 5 with pixel = col+32*row; BLOCK read at 5 → out_valid 2 cycles after ack, out_data pixel(r,j) = j+32r, out_block=1, out_last=1.
- ROW read at addr 5, rd_row=3 → single beat, low 256 bits = 96..127, upper 1792 bits zero, out_row=3, out_last=1.
- BURST at addr 5, out_ready=1 → 8 beats on 8 consecutive cycles, out_row 0..7, out_last only on row 7.
- BURST with out_ready toggling 1,0,0,1,… → all 8 rows delivered once, in order, data stable during stalls, credit never below 0.
- Write and read address 5 bank 0 in the same cycle → read returns old value; read the next cycle returns new value.
- Assert rst 2 cycles into a stalled BURST → outputs 0 at once; after release, no residual beat; next BLOCK read completes normally.

Source files
------------

// File: rtl/ref_mem_pkg.sv
// Shared definitions for the banked reference-pixel store: read-mode encoding
// and the read-control FSM state type.
package ref_mem_pkg;

    localparam logic [1:0] MODE_BLOCK = 2'd0;
    localparam logic [1:0] MODE_ROW   = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE_ONE = 2'd1,
        ST_BURST     = 2'd2
    } state_t;

endpackage

// File: rtl/ref_mem_banked_if.sv
// Bus bundle for ref_mem_banked: write path, read command, output beat stream
// and the exposed read-FSM state.
interface ref_mem_banked_if #(
    parameter int PIXEL_W  = 8,
    parameter int COLS     = 32,
    parameter int ROWS     = 8,
    parameter int DEPTH    = 96,
    parameter int WR_LANES = 4,
    parameter int AW       = $clog2(DEPTH),
    parameter int RW       = $clog2(ROWS)
);
    logic                             wr_en;
    logic [COLS-1:0]                  wr_bank_mask;
    logic [COLS*AW-1:0]               wr_addr;
    logic [WR_LANES*ROWS*PIXEL_W-1:0] wr_data;

    logic                             rd_req;
    logic [1:0]                       rd_mode;
    logic [AW-1:0]                    rd_addr;
    logic [RW-1:0]                    rd_row;
    logic                             rd_ack;

    // A beat transfers on a clock edge where out_valid && out_ready; while
    // out_valid && !out_ready the beat fields are held unchanged.
    logic [ROWS*COLS*PIXEL_W-1:0]     out_data;
    logic [RW-1:0]                    out_row;
    logic                             out_block;
    logic                             out_last;
    logic                             out_valid;
    logic                             out_ready;

    ref_mem_pkg::state_t              dbg_state;

    modport master (
        output wr_en, wr_bank_mask, wr_addr, wr_data,
        output rd_req, rd_mode, rd_addr, rd_row, out_ready,
        input  rd_ack, out_data, out_row, out_block, out_last, out_valid, dbg_state
    );

    modport slave (
        input  wr_en, wr_bank_mask, wr_addr, wr_data,
        input  rd_req, rd_mode, rd_addr, rd_row, out_ready,
        output rd_ack, out_data, out_row, out_block, out_last, out_valid, dbg_state
    );

endinterface

// File: rtl/ref_bank.sv
// One column bank: synchronous RAM with a registered read port, read-first
// when the same address is written and read in one cycle.
module ref_bank #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata holds its value whenever re is low, which the top relies on while stalled.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: rtl/ref_mem_banked.sv
// Banked reference-pixel store: COLS column banks, read out as a block, a single
// row or a row burst through a credit-controlled 2-entry output buffer.
module ref_mem_banked
    import ref_mem_pkg::*;
#(
    parameter int PIXEL_W  = 8,
    parameter int COLS     = 32,
    parameter int ROWS     = 8,
    parameter int DEPTH    = 96,
    parameter int WR_LANES = 4,
    parameter int AW       = $clog2(DEPTH),
    parameter int RW       = $clog2(ROWS)
) (
    input logic             clk,
    input logic             rst,
    ref_mem_banked_if.slave bus
);

    localparam int WORD_W = ROWS*PIXEL_W;
    localparam int OUT_W  = ROWS*COLS*PIXEL_W;

    state_t          state_q, state_d;
    logic [1:0]      mode_q;
    logic [AW-1:0]   addr_q;
    logic [RW-1:0]   row_q;
    logic [1:0]      credit_q;
    logic            rd_ack, issue, bank_re, pop;
    logic [AW-1:0]   bank_raddr;
    logic [WORD_W-1:0] bank_rdata [COLS];

    for (genvar j = 0; j < COLS; j++) begin : g_bank
        ref_bank #(.WIDTH(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk   (clk),
            .we    (bus.wr_en && bus.wr_bank_mask[j]),
            .waddr (bus.wr_addr[AW*j +: AW]),
            .wdata (bus.wr_data[WORD_W*(j % WR_LANES) +: WORD_W]),
            .re    (bank_re),
            .raddr (bank_raddr),
            .rdata (bank_rdata[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_BLOCK;
            addr_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (rd_ack) begin
                mode_q <= bus.rd_mode;
                addr_q <= bus.rd_addr;
                row_q  <= (bus.rd_mode == MODE_ROW) ? bus.rd_row : '0;
            end else if (issue && state_q == ST_BURST) begin
                row_q <= row_q + RW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rd_req) begin
                    if (bus.rd_mode == MODE_BURST)     state_d = ST_BURST;
                    else if (bus.rd_mode != MODE_RSVD) state_d = ST_ISSUE_ONE;
                end
            end
            ST_ISSUE_ONE: if (credit_q != 2'd0) state_d = ST_IDLE;
            ST_BURST:     if (credit_q != 2'd0 && row_q == RW'(ROWS-1)) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // The bank word is fetched in the ack cycle; "issue" moves the fetched word
    // into the buffer. In BURST each issue also re-reads the word for the next row.
    always_comb begin
        rd_ack     = 1'b0;
        issue      = 1'b0;
        bank_re    = 1'b0;
        bank_raddr = addr_q;
        case (state_q)
            ST_IDLE: begin
                rd_ack     = bus.rd_req;
                bank_re    = bus.rd_req && (bus.rd_mode != MODE_RSVD);
                bank_raddr = bus.rd_addr;
            end
            ST_ISSUE_ONE: issue = (credit_q != 2'd0);
            ST_BURST: begin
                issue   = (credit_q != 2'd0);
                bank_re = issue && (row_q != RW'(ROWS-1));
            end
            default: ;
        endcase
    end

    logic [OUT_W-1:0] fmt_data;
    logic [RW-1:0]    fmt_row;
    logic             fmt_block, fmt_last;

    always_comb begin
        fmt_data  = '0;
        fmt_block = (mode_q == MODE_BLOCK);
        fmt_row   = fmt_block ? '0 : row_q;
        fmt_last  = (mode_q != MODE_BURST) || (row_q == RW'(ROWS-1));
        for (int j = 0; j < COLS; j++) begin
            if (fmt_block) begin
                for (int r = 0; r < ROWS; r++)
                    fmt_data[PIXEL_W*(COLS*r+j) +: PIXEL_W] = bank_rdata[j][PIXEL_W*r +: PIXEL_W];
            end else begin
                fmt_data[PIXEL_W*j +: PIXEL_W] = bank_rdata[j][PIXEL_W*row_q +: PIXEL_W];
            end
        end
    end

    logic [OUT_W-1:0] buf_data  [2];
    logic [RW-1:0]    buf_row   [2];
    logic             buf_block [2];
    logic             buf_last  [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;

    assign pop = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i]  <= '0;
                buf_row[i]   <= '0;
                buf_block[i] <= 1'b0;
                buf_last[i]  <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            credit_q <= 2'd2;
        end else begin
            if (issue) begin
                buf_data[wr_ptr]  <= fmt_data;
                buf_row[wr_ptr]   <= fmt_row;
                buf_block[wr_ptr] <= fmt_block;
                buf_last[wr_ptr]  <= fmt_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count    <= count    + {1'b0, issue} - {1'b0, pop};
            credit_q <= credit_q - {1'b0, issue} + {1'b0, pop};
        end
    end

    assign bus.rd_ack    = rd_ack;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = buf_data[rd_ptr];
    assign bus.out_row   = buf_row[rd_ptr];
    assign bus.out_block = buf_block[rd_ptr];
    assign bus.out_last  = buf_last[rd_ptr];
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ref_mem_banked.sv
// Bench for ref_mem_banked: directed plus randomized reads/writes checked by a
// scoreboard fed from a pixel-array reference model.
module tb_ref_mem_banked;
    import ref_mem_pkg::*;

    localparam int PIXEL_W  = 8;
    localparam int COLS     = 32;
    localparam int ROWS     = 8;
    localparam int DEPTH    = 96;
    localparam int WR_LANES = 4;
    localparam int AW       = $clog2(DEPTH);
    localparam int RW       = $clog2(ROWS);
    localparam int WORD_W   = ROWS*PIXEL_W;
    localparam int OUT_W    = ROWS*COLS*PIXEL_W;
    localparam int WD_W     = WR_LANES*WORD_W;
    localparam int EW       = OUT_W + RW + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    ref_mem_banked_if #(.PIXEL_W(PIXEL_W), .COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH),
                        .WR_LANES(WR_LANES), .AW(AW), .RW(RW)) bus ();

    ref_mem_banked #(.PIXEL_W(PIXEL_W), .COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH),
                     .WR_LANES(WR_LANES), .AW(AW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- scoreboard state / reference model ----------------
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    int beat_cyc_q[$];
    int beat_cnt = 0;
    int ready_mode = 0;
    int pat = 0;
    int addr_list[6] = '{5, 0, 17, 42, 63, 95};

    logic [PIXEL_W-1:0] mpix [DEPTH][COLS][ROWS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_data(input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int p = 0; p < OUT_W/PIXEL_W; p++)
            if (bad < 0 && act[PIXEL_W*p +: PIXEL_W] !== exp[PIXEL_W*p +: PIXEL_W]) bad = p;
        if (bad >= 0) begin
            errors++;
            $display("FAIL beat_data: pixel %0d got %0h expected %0h (cycle %0d)",
                     bad, act[PIXEL_W*bad +: PIXEL_W], exp[PIXEL_W*bad +: PIXEL_W], cyc);
        end
    endtask

    function automatic void model_write(input logic [COLS-1:0] m, input logic [COLS*AW-1:0] a,
                                        input logic [WD_W-1:0] d);
        for (int j = 0; j < COLS; j++)
            if (m[j])
                for (int r = 0; r < ROWS; r++)
                    mpix[int'(a[AW*j +: AW])][j][r] = d[WORD_W*(j % WR_LANES) + PIXEL_W*r +: PIXEL_W];
    endfunction

    function automatic logic [EW-1:0] row_beat(input int a, input int r, input logic last);
        logic [OUT_W-1:0] d;
        d = '0;
        for (int j = 0; j < COLS; j++) d[PIXEL_W*j +: PIXEL_W] = mpix[a][j][r];
        return {last, 1'b0, RW'(r), d};
    endfunction

    function automatic void push_expect(input logic [1:0] mode, input int a, input int row);
        logic [OUT_W-1:0] d;
        d = '0;
        if (mode == MODE_BLOCK) begin
            for (int r = 0; r < ROWS; r++)
                for (int j = 0; j < COLS; j++)
                    d[PIXEL_W*(COLS*r+j) +: PIXEL_W] = mpix[a][j][r];
            exp_q.push_back({1'b1, 1'b1, RW'(0), d});
        end else if (mode == MODE_ROW) begin
            exp_q.push_back(row_beat(a, row, 1'b1));
        end else if (mode == MODE_BURST) begin
            for (int r = 0; r < ROWS; r++) exp_q.push_back(row_beat(a, r, r == ROWS-1));
        end
    endfunction

    // ---------------- consumer ready pattern ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            2: begin bus.out_ready = (pat % 3 == 0); pat++; end
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    logic [EW-1:0] held;
    logic          held_v = 1'b0;

    always @(negedge clk) begin
        logic [EW-1:0] cur, e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            cur = {bus.out_last, bus.out_block, bus.out_row, bus.out_data};
            if (held_v) begin
                check("stall_valid_held", bus.out_valid, 1);
                check("stall_beat_stable", cur == held, 1);
            end
            held_v = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                held   = cur;
                held_v = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                beat_cnt++;
                beat_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: row %0d last %0d arrived, expected none (cycle %0d)",
                             bus.out_row, bus.out_last, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check_data(bus.out_data, e[OUT_W-1:0]);
                    check("beat_row", bus.out_row, e[OUT_W +: RW]);
                    check("beat_block", bus.out_block, e[OUT_W+RW]);
                    check("beat_last", bus.out_last, e[OUT_W+RW+1]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wr_beat(input logic [COLS-1:0] m, input logic [COLS*AW-1:0] a, input logic [WD_W-1:0] d);
        bus.wr_en = 1'b1; bus.wr_bank_mask = m; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        model_write(m, a, d);
    endtask

    task automatic rd_cmd(input logic [1:0] mode, input int a, input int row, output int ack_cyc);
        bit got;
        got = 0;
        ack_cyc = -1;
        bus.rd_req = 1'b1; bus.rd_mode = mode; bus.rd_addr = AW'(a); bus.rd_row = RW'(row);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.rd_ack) begin
                got = 1;
                ack_cyc = cyc;
                push_expect(mode, a, row);
            end
            @(posedge clk); #1;
        end
        bus.rd_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: mode %0d addr %0d got no ack in 50 cycles", mode, a);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still outstanding", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [COLS*AW-1:0] same_addr(input int a);
        logic [COLS*AW-1:0] v;
        for (int j = 0; j < COLS; j++) v[AW*j +: AW] = AW'(a);
        return v;
    endfunction

    function automatic logic [WD_W-1:0] rand_data();
        logic [WD_W-1:0] d;
        for (int i = 0; i < WD_W/32; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int ack, n0;
        logic [COLS-1:0] m;
        logic [WD_W-1:0] d;
        logic [COLS*AW-1:0] a;

        bus.wr_en = 1'b0; bus.wr_bank_mask = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_mode = '0; bus.rd_addr = '0; bus.rd_row = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data_ones", $countones(bus.out_data), 0);
        check("rst_out_row", bus.out_row, 0);
        check("rst_out_block", bus.out_block, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_rd_ack", bus.rd_ack, 0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        rst = 1'b0;
        @(posedge clk); #1;

        // address 5: pixel(row r, col j) = j + 32*r, one 4-bank group per beat
        for (int g = 0; g < COLS/WR_LANES; g++) begin
            m = '0;
            m[WR_LANES*g +: WR_LANES] = '1;
            d = '0;
            for (int k = 0; k < WR_LANES; k++)
                for (int r = 0; r < ROWS; r++)
                    d[WORD_W*k + PIXEL_W*r +: PIXEL_W] = PIXEL_W'(WR_LANES*g + k + COLS*r);
            wr_beat(m, same_addr(5), d);
        end
        for (int i = 1; i < 6; i++)
            for (int g = 0; g < COLS/WR_LANES; g++) begin
                m = '0;
                m[WR_LANES*g +: WR_LANES] = '1;
                wr_beat(m, same_addr(addr_list[i]), rand_data());
            end

        // BLOCK read: 2-cycle latency with the buffer empty
        ready_mode = 0;
        beat_cyc_q.delete();
        rd_cmd(MODE_BLOCK, 5, 0, ack);
        drain();
        check("block_latency", beat_cyc_q.size() > 0 ? beat_cyc_q[0] - ack : -1, 2);
        check("block_beats", beat_cyc_q.size(), 1);

        // ROW read of row 3
        beat_cyc_q.delete();
        rd_cmd(MODE_ROW, 5, 3, ack);
        drain();
        check("row_beats", beat_cyc_q.size(), 1);

        // BURST with ready held high: 8 beats on consecutive cycles
        beat_cyc_q.delete();
        rd_cmd(MODE_BURST, 5, 0, ack);
        drain();
        check("burst_beats", beat_cyc_q.size(), ROWS);
        check("burst_span", beat_cyc_q.size() == ROWS ? beat_cyc_q[ROWS-1] - beat_cyc_q[0] : -1, ROWS-1);

        // BURST against a 1,0,0 ready pattern
        pat = 0;
        ready_mode = 2;
        beat_cyc_q.delete();
        rd_cmd(MODE_BURST, 5, 0, ack);
        drain();
        check("burst_stall_beats", beat_cyc_q.size(), ROWS);
        ready_mode = 0;

        // reserved mode: acked, no beat
        n0 = beat_cnt;
        rd_cmd(MODE_RSVD, 5, 0, ack);
        drain();
        check("rsvd_no_beat", beat_cnt - n0, 0);

        // zero-mask write is a no-op
        wr_beat('0, same_addr(5), rand_data());
        rd_cmd(MODE_BLOCK, 5, 0, ack);
        drain();

        // write and read bank 0 address 5 in one cycle: old data, then new data
        m = '0;
        m[0] = 1'b1;
        d = rand_data();
        bus.wr_en = 1'b1; bus.wr_bank_mask = m; bus.wr_addr = same_addr(5); bus.wr_data = d;
        rd_cmd(MODE_BLOCK, 5, 0, ack);
        bus.wr_en = 1'b0;
        model_write(m, same_addr(5), d);
        drain();
        rd_cmd(MODE_BLOCK, 5, 0, ack);
        drain();

        // reset two cycles into a stalled BURST
        ready_mode = 3;
        rd_cmd(MODE_BURST, 5, 0, ack);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data_ones", $countones(bus.out_data), 0);
        check("midrst_out_row", bus.out_row, 0);
        check("midrst_out_last", bus.out_last, 0);
        check("midrst_out_block", bus.out_block, 0);
        check("midrst_state", bus.dbg_state, ST_IDLE);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        n0 = beat_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("no_residual_beat", beat_cnt - n0, 0);
        beat_cyc_q.delete();
        rd_cmd(MODE_BLOCK, 5, 0, ack);
        drain();
        check("post_rst_block_latency", beat_cyc_q.size() > 0 ? beat_cyc_q[0] - ack : -1, 2);

        // randomized mix of writes and commands with a random consumer
        ready_mode = 1;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                m = '0;
                for (int i = 0; i < COLS/32; i++) m[32*i +: 32] = $urandom();
                for (int j = 0; j < COLS; j++) a[AW*j +: AW] = AW'(addr_list[$urandom_range(0, 5)]);
                wr_beat(m, a, rand_data());
            end else begin
                rd_cmd(2'($urandom_range(0, 3)), addr_list[$urandom_range(0, 5)],
                       $urandom_range(0, ROWS-1), ack);
                drain();
            end
        end
        ready_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
